// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Size encodings and byte-count decode shared by the
//               immediate/displacement extractor.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    localparam logic [1:0] IMM_SZ_8    = 2'b00;
    localparam logic [1:0] IMM_SZ_16   = 2'b01;
    localparam logic [1:0] IMM_SZ_32   = 2'b10;
    localparam logic [1:0] IMM_SZ_NONE = 2'b11;

    function automatic logic [2:0] imm_nbytes(input logic [1:0] size);
        case (size)
            IMM_SZ_8  : return 3'd1;
            IMM_SZ_16 : return 3'd2;
            IMM_SZ_32 : return 3'd4;
            default   : return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_field_extract.sv
`default_nettype none
// ============================================================================
// Module      : imm_field_extract
// Description : Little-endian field pick from the instruction window with
//               optional sign extension and window-overrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_field_extract
    import imm_pkg::*;
#(
    parameter int IR_BYTES = 16,
    parameter int DATA_W   = 32,
    parameter int OFF_W    = 4
) (
    input  logic [IR_BYTES*8-1:0] ir,
    input  logic [OFF_W-1:0]      off,
    input  logic [1:0]            size,
    input  logic                  sext,
    output logic [DATA_W-1:0]     value,
    output logic                  err
);

    localparam int                 c_SUM_W = OFF_W + 1;
    localparam logic [c_SUM_W-1:0] c_WIN   = c_SUM_W'(IR_BYTES);

    logic [2:0]         w_nbytes;
    logic [c_SUM_W-1:0] w_end;
    logic [7:0]         w_byte [4];
    logic               w_fill;

    // One bit of headroom so off+nbytes past the window cannot wrap back in.
    assign w_nbytes = imm_nbytes(size);
    assign w_end    = {1'b0, off} + c_SUM_W'(w_nbytes);
    assign err      = (size != IMM_SZ_NONE) && (w_end > c_WIN);

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_byte[j] = 8'h00;
            for (int k = 0; k < IR_BYTES; k++) begin
                if (({1'b0, off} + c_SUM_W'(j)) == c_SUM_W'(k)) begin
                    w_byte[j] = ir[IR_BYTES*8-1-8*k -: 8];
                end
            end
        end
    end

    always_comb begin
        case (size)
            IMM_SZ_8  : w_fill = w_byte[0][7];
            IMM_SZ_16 : w_fill = w_byte[1][7];
            IMM_SZ_32 : w_fill = w_byte[3][7];
            default   : w_fill = 1'b0;
        endcase
        value = {DATA_W{sext & w_fill}};
        case (size)
            IMM_SZ_8  : value[7:0]  = w_byte[0];
            IMM_SZ_16 : value[15:0] = {w_byte[1], w_byte[0]};
            IMM_SZ_32 : value[31:0] = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
            default   : value       = '0;
        endcase
        if (err) begin
            value = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imm_disp_extract.sv
`default_nettype none
// ============================================================================
// Module      : imm_disp_extract
// Description : Extracts immediate and displacement fields and queues them in
//               a 2-entry registered buffer with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_disp_extract
    import imm_pkg::*;
#(
    parameter int IR_BYTES = 16,
    parameter int DATA_W   = 32,
    parameter int OFF_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IR_BYTES*8-1:0] ir,
    input  logic [OFF_W-1:0]      imm_off,
    input  logic [1:0]            imm_size,
    input  logic                  imm_sext,
    input  logic [OFF_W-1:0]      disp_off,
    input  logic [1:0]            disp_size,
    input  logic                  disp_sext,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     imm,
    output logic [DATA_W-1:0]     disp,
    output logic                  out_err
);

    // Entry layout depends on DATA_W, so the record type is scoped here.
    typedef struct packed {
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] disp;
        logic              err;
    } entry_t;

    logic [DATA_W-1:0] w_imm_val;
    logic [DATA_W-1:0] w_disp_val;
    logic              w_imm_err;
    logic              w_disp_err;
    entry_t            w_new;
    logic              w_push;
    logic              w_pop;

    entry_t            r_mem [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;

    imm_field_extract #(
        .IR_BYTES (IR_BYTES),
        .DATA_W   (DATA_W),
        .OFF_W    (OFF_W)
    ) u_imm (
        .ir    (ir),
        .off   (imm_off),
        .size  (imm_size),
        .sext  (imm_sext),
        .value (w_imm_val),
        .err   (w_imm_err)
    );

    imm_field_extract #(
        .IR_BYTES (IR_BYTES),
        .DATA_W   (DATA_W),
        .OFF_W    (OFF_W)
    ) u_disp (
        .ir    (ir),
        .off   (disp_off),
        .size  (disp_size),
        .sext  (disp_sext),
        .value (w_disp_val),
        .err   (w_disp_err)
    );

    assign w_new     = {w_imm_val, w_disp_val, w_imm_err | w_disp_err};
    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Outputs come straight from the head register; nothing from ir leaks through.
    assign imm     = r_mem[r_rd_ptr].imm;
    assign disp    = r_mem[r_rd_ptr].disp;
    assign out_err = r_mem[r_rd_ptr].err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_new;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10   : r_count <= r_count + 2'd1;
                2'b01   : r_count <= r_count - 2'd1;
                default : r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_disp_extract.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_disp_extract
// Description : Directed self-checking bench for imm_disp_extract.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_disp_extract;

    localparam int IR_BYTES = 16;
    localparam int DATA_W   = 32;
    localparam int OFF_W    = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [IR_BYTES*8-1:0] ir;
    logic [OFF_W-1:0]      imm_off;
    logic [1:0]            imm_size;
    logic                  imm_sext;
    logic [OFF_W-1:0]      disp_off;
    logic [1:0]            disp_size;
    logic                  disp_sext;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     disp;
    logic                  out_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  ioff;
        logic [1:0]  isz;
        logic        isx;
        logic [3:0]  doff;
        logic [1:0]  dsz;
        logic        dsx;
        logic [31:0] eimm;
        logic [31:0] edisp;
        logic        eerr;
    } vec_t;

    imm_disp_extract #(
        .IR_BYTES (IR_BYTES),
        .DATA_W   (DATA_W),
        .OFF_W    (OFF_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir        (ir),
        .imm_off   (imm_off),
        .imm_size  (imm_size),
        .imm_sext  (imm_sext),
        .disp_off  (disp_off),
        .disp_size (disp_size),
        .disp_sext (disp_sext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .disp      (disp),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic set_fields(input logic [3:0] ioff, input logic [1:0] isz, input logic isx,
                              input logic [3:0] doff, input logic [1:0] dsz, input logic dsx);
        imm_off   = ioff;
        imm_size  = isz;
        imm_sext  = isx;
        disp_off  = doff;
        disp_size = dsz;
        disp_sext = dsx;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h exp 0", imm); end
        checks++; if (disp !== 32'h0) begin errors++; $display("FAIL reset_disp got %h exp 0", disp); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", out_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dword;
        out_ready = 1'b1;
        set_fields(4'd3, 2'b10, 1'b0, 4'd0, 2'b11, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dword_valid got %b exp 1", out_valid); end
        checks++; if (imm !== 32'h66554433) begin errors++; $display("FAIL dword_imm got %h exp 66554433", imm); end
        checks++; if (disp !== 32'h0) begin errors++; $display("FAIL dword_disp got %h exp 0", disp); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL dword_err got %b exp 0", out_err); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dword_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_table(input string name, input vec_t v [5]);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_fields(v[i].ioff, v[i].isz, v[i].isx, v[i].doff, v[i].dsz, v[i].dsx);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s[%0d]_valid got %b exp 1", name, i, out_valid); end
            checks++; if (imm !== v[i].eimm) begin errors++; $display("FAIL %s[%0d]_imm got %h exp %h", name, i, imm, v[i].eimm); end
            checks++; if (disp !== v[i].edisp) begin errors++; $display("FAIL %s[%0d]_disp got %h exp %h", name, i, disp, v[i].edisp); end
            checks++; if (out_err !== v[i].eerr) begin errors++; $display("FAIL %s[%0d]_err got %b exp %b", name, i, out_err, v[i].eerr); end
            @(negedge clk);
        end
    endtask

    task automatic test_sext;
        vec_t v [5];
        v[0] = '{4'd8,  2'b00, 1'b1, 4'd9,  2'b01, 1'b1, 32'hFFFFFF88, 32'hFFFFAA99, 1'b0};
        v[1] = '{4'd8,  2'b00, 1'b0, 4'd9,  2'b01, 1'b0, 32'h00000088, 32'h0000AA99, 1'b0};
        v[2] = '{4'd3,  2'b01, 1'b1, 4'd0,  2'b11, 1'b1, 32'h00004433, 32'h00000000, 1'b0};
        v[3] = '{4'd15, 2'b00, 1'b1, 4'd12, 2'b10, 1'b1, 32'hFFFFFFFF, 32'hFFEEDDCC, 1'b0};
        v[4] = '{4'd9,  2'b10, 1'b1, 4'd7,  2'b00, 1'b1, 32'hCCBBAA99, 32'h00000077, 1'b0};
        test_table("sext", v);
    endtask

    task automatic test_overrun;
        vec_t v [5];
        v[0] = '{4'd14, 2'b10, 1'b0, 4'd0,  2'b11, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
        v[1] = '{4'd12, 2'b10, 1'b0, 4'd0,  2'b11, 1'b0, 32'hFFEEDDCC, 32'h00000000, 1'b0};
        v[2] = '{4'd15, 2'b01, 1'b1, 4'd15, 2'b00, 1'b0, 32'h00000000, 32'h000000FF, 1'b1};
        v[3] = '{4'd0,  2'b11, 1'b1, 4'd15, 2'b11, 1'b1, 32'h00000000, 32'h00000000, 1'b0};
        v[4] = '{4'd13, 2'b10, 1'b1, 4'd14, 2'b01, 1'b1, 32'h00000000, 32'hFFFFFFEE, 1'b1};
        test_table("overrun", v);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        set_fields(4'd0, 2'b00, 1'b0, 4'd0, 2'b11, 1'b0);
        in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b exp 1", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
        checks++; if (imm !== 32'h00) begin errors++; $display("FAIL bp_head1 got %h exp 0", imm); end
        set_fields(4'd1, 2'b00, 1'b0, 4'd0, 2'b11, 1'b0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2 got %b exp 0", in_ready); end
        checks++; if (imm !== 32'h00) begin errors++; $display("FAIL bp_hold1 got %h exp 0", imm); end
        set_fields(4'd2, 2'b00, 1'b0, 4'd0, 2'b11, 1'b0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready3 got %b exp 0", in_ready); end
        checks++; if (imm !== 32'h00 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold2 got %h/%b exp 0/1", imm, out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b exp 1", in_ready); end
        checks++; if (imm !== 32'h11) begin errors++; $display("FAIL bp_second got %h exp 11", imm); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (imm !== 32'h22 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got %h/%b exp 22/1", imm, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        set_fields(4'd0, 2'b00, 1'b0, 4'd0, 2'b11, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        set_fields(4'd1, 2'b00, 1'b0, 4'd0, 2'b11, 1'b0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full got %b exp 0", in_ready); end
        set_fields(4'd2, 2'b00, 1'b0, 4'd0, 2'b11, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush2_ready got %b exp 1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_empty got %b exp 0", out_valid); end
        // Flush at count=1 with an accepted push: the push must still vanish.
        set_fields(4'd3, 2'b00, 1'b0, 4'd0, 2'b11, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL flush1_pre got %b/%b exp 1/1", out_valid, in_ready); end
        set_fields(4'd4, 2'b00, 1'b0, 4'd0, 2'b11, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush1_valid got %b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush1_empty got %b exp 0", out_valid); end
        out_ready = 1'b1;
        set_fields(4'd5, 2'b00, 1'b0, 4'd0, 2'b11, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || imm !== 32'h55) begin errors++; $display("FAIL flush_recover got %b/%h exp 1/55", out_valid, imm); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0;
        set_fields(4'd3, 2'b10, 1'b0, 4'd9, 2'b01, 1'b1);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imm !== 32'h66554433 || disp !== 32'hFFFFAA99) begin errors++; $display("FAIL mrst_pre got %h/%h exp 66554433/ffffaa99", imm, disp); end
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mrst_hs got %b/%b exp 0/1", out_valid, in_ready); end
        checks++; if (imm !== 32'h0 || disp !== 32'h0 || out_err !== 1'b0) begin errors++; $display("FAIL mrst_data got %h/%h/%b exp 0/0/0", imm, disp, out_err); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_imm;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_fields(4'(k), 2'b00, 1'b0, 4'(9 - k), 2'b00, 1'b0);
            @(negedge clk);
            exp_imm = 32'(17 * k);
            checks++; if (out_valid !== 1'b1 || imm !== exp_imm || disp !== 32'(17 * (9 - k))) begin
                errors++; $display("FAIL b2b[%0d] got %b/%h/%h exp 1/%h/%h", k, out_valid, imm, disp, exp_imm, 32'(17 * (9 - k)));
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, in_ready); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ir        = 128'h00112233445566778899AABBCCDDEEFF;
        set_fields(4'd0, 2'b11, 1'b0, 4'd0, 2'b11, 1'b0);
        test_reset();
        test_dword();
        test_sext();
        test_overrun();
        test_backpressure();
        test_flush();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
